// File: rtl/fetch_stage_if.sv
// Instruction-memory request/acknowledge bus between the fetch stage and imem.
interface fetch_stage_if;
    logic        imem_req;
    logic [15:0] imem_addr;
    logic        imem_ack;
    logic [15:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ack, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ack, imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch with PC, one-word skid buffer, redirect handling and IF/ID register.
module fetch_stage #(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter logic [15:0] PC_STEP      = 16'd2,
    parameter logic [15:0] BUBBLE_INSTR = 16'h1000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                stall,
    input  logic                redirect_valid,
    input  logic [15:0]         redirect_pc,
    fetch_stage_if.master       imem,
    output logic                if_id_valid,
    output logic [15:0]         if_id_instr,
    output logic [15:0]         if_id_pc_next,
    output logic [3:0]          opcode
);

    localparam logic [1:0] FETCH = 2'd0;
    localparam logic [1:0] SKID  = 2'd1;
    localparam logic [1:0] DROP  = 2'd2;

    logic [1:0]  state;
    logic        started;
    logic [15:0] pc;
    logic [15:0] pc_step;
    logic [15:0] skid_instr;
    logic [15:0] skid_pc_next;
    logic [15:0] target;
    logic        ack;
    logic        new_valid;
    logic [15:0] new_instr;
    logic [15:0] new_pc_next;

    function automatic logic [15:0] pc_inc(input logic [15:0] a);
        return a + PC_STEP;
    endfunction

    assign pc_step        = pc_inc(pc);
    // Request held low until the first clock after reset release, and while the skid is full.
    assign imem.imem_req  = started && (state != SKID);
    // In DROP the PC is frozen, so it still names the outstanding address.
    assign imem.imem_addr = pc;
    assign ack            = imem.imem_req && imem.imem_ack;
    assign opcode         = if_id_instr[15:12];

    always_comb begin
        new_valid   = 1'b0;
        new_instr   = imem.imem_rdata;
        new_pc_next = pc_step;
        if (state == SKID) begin
            new_valid   = 1'b1;
            new_instr   = skid_instr;
            new_pc_next = skid_pc_next;
        end else if (state == FETCH && ack) begin
            new_valid = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= FETCH;
            started      <= 1'b0;
            pc           <= RESET_PC;
            skid_instr   <= 16'h0000;
            skid_pc_next <= 16'h0000;
            target       <= 16'h0000;
        end else begin
            started <= 1'b1;
            case (state)
                FETCH: begin
                    if (ack) begin
                        if (redirect_valid) begin
                            pc <= redirect_pc;
                        end else begin
                            pc <= pc_step;
                            if (stall) begin
                                skid_instr   <= imem.imem_rdata;
                                skid_pc_next <= pc_step;
                                state        <= SKID;
                            end
                        end
                    end else if (started && redirect_valid) begin
                        target <= redirect_pc;
                        state  <= DROP;
                    end
                end
                SKID: begin
                    if (redirect_valid) begin
                        pc    <= redirect_pc;
                        state <= FETCH;
                    end else if (!stall) begin
                        state <= FETCH;
                    end
                end
                DROP: begin
                    if (redirect_valid) target <= redirect_pc;
                    // The stale word is discarded; the newest redirect wins.
                    if (ack) begin
                        pc    <= redirect_valid ? redirect_pc : target;
                        state <= FETCH;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    // IF/ID register: flush beats stall, stall beats a new word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            if_id_valid   <= 1'b0;
            if_id_instr   <= BUBBLE_INSTR;
            if_id_pc_next <= 16'h0000;
        end else if (redirect_valid) begin
            if_id_valid <= 1'b0;
            if_id_instr <= BUBBLE_INSTR;
        end else if (!stall) begin
            if (new_valid) begin
                if_id_valid   <= 1'b1;
                if_id_instr   <= new_instr;
                if_id_pc_next <= new_pc_next;
            end else begin
                if_id_valid <= 1'b0;
                if_id_instr <= BUBBLE_INSTR;
            end
        end
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage with IF/ID pipeline register for the 16-bit processor; sits directly upstream of the control decoder.
- Owns the PC and drives a request/acknowledge instruction-memory port.
- Applies jump, branch and jr redirects, honours hazard stalls, and buffers one fetched word.
- Presents the IF/ID instruction; bits [15:12] go straight to the control decoder's opcode input.

Parameters:
- RESET_PC, 16'h0000, PC value loaded on reset.
- PC_STEP, 2, PC increment per sequential fetch (byte-addressed, 16-bit instructions).
- BUBBLE_INSTR, 16'h1000, word inserted on flush/empty. Opcode 0001 decodes with reg_write=0, mem_write=0, branch=0, jump=0.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high; all state clears immediately.
- stall  in  1  hazard unit: hold IF/ID and PC.
- redirect_valid  in  1  taken branch/jump/jr this cycle.
- redirect_pc  in  16  redirect target.
- imem_req  out  1  fetch request.
- imem_addr  out  16  fetch address; stable while imem_req=1 until imem_ack.
- imem_ack  in  1  imem_rdata valid for current imem_addr; may occur in the same cycle as imem_req or later.
- imem_rdata  in  16  fetched instruction.
- if_id_valid  out  1  IF/ID holds a real instruction.
- if_id_instr  out  16  IF/ID instruction (BUBBLE_INSTR when invalid).
- if_id_pc_next  out  16  fetch PC + PC_STEP, for jal link and branch base.
- opcode  out  4  if_id_instr[15:12], to control.

Behaviour:
- All registers are async reset, active-high.
- Reset values:
  - pc=RESET_PC; state=FETCH; if_id_valid=0; if_id_instr=BUBBLE_INSTR; if_id_pc_next=0.
  - Skid buffer invalid; redirect target register = 0.
  - Outputs: imem_req=0 while reset is asserted, 1 from the first clock after release; opcode=4'b0001.
- imem_addr = pc, or the latched outstanding address in DROP. The address never changes while a request is unacknowledged.
- States: FETCH, SKID, DROP.
  - FETCH (imem_req=1):
    - ack & redirect_valid: discard rdata; pc<=redirect_pc; stay FETCH.
    - ack & !stall: IF/ID<=rdata, valid=1, pc_next=pc+PC_STEP; pc<=pc+PC_STEP.
    - ack & stall: skid<=rdata and pc+PC_STEP; pc<=pc+PC_STEP; go SKID.
    - !ack & redirect_valid: target<=redirect_pc; go DROP.
    - !ack otherwise: hold.
  - SKID (imem_req=0):
    - redirect_valid: drop skid; pc<=redirect_pc; go FETCH.
    - !stall: IF/ID<=skid, valid=1; go FETCH.
    - stall: hold.
  - DROP (imem_req=1, old address held):
    - redirect_valid: target<=redirect_pc (last redirect wins).
    - ack: discard rdata; pc<=target, or redirect_pc if redirect_valid is asserted that cycle; go FETCH.
- IF/ID priority order, highest first:
  1. redirect_valid: if_id_valid<=0, instr<=BUBBLE_INSTR (flush beats stall).
  2. stall: hold.
  3. New word delivered: load it.
  4. Otherwise: valid<=0, instr<=BUBBLE_INSTR.
- Arithmetic: PC adds wrap modulo 2^16 (16'hFFFE+2 = 16'h0000); no other width rules.
- Throughput: one instruction per cycle when ack is combinational and there are no stalls.
- Fetch-to-IF/ID latency: 1 clock after the ack edge.
- Reset mid-request: the request is abandoned; the memory must tolerate a dropped request.

Test Plan:
- Reset release, imem_ack tied to imem_req, rdata=16'h0123,16'h2456,... → imem_addr 0,2,4 on consecutive cycles; if_id_instr 0123 then 2456; opcode 0 then 2; if_id_pc_next 2 then 4.
- Ack delayed 3 cycles at addr 4 → imem_addr held at 4 for 3 cycles; IF/ID bubble (instr 1000, valid 0) during the wait.
- Stall asserted in the same cycle as the ack of 16'hA123 → state SKID, imem_req=0, IF/ID unchanged. Stall drops → if_id_instr=A123 next cycle, fetching resumes.
- redirect_valid, redirect_pc=16'h0040 while ack pending at addr 6 (DROP) → addr 6 held until ack; its data discarded; next imem_addr=0x40; IF/ID flushed to valid 0.
- redirect and stall together with a valid IF/ID → flush wins (valid 0, opcode 0001); skid buffer discarded.
- pc=16'hFFFE with ack → next imem_addr=16'h0000; assert reset mid-DROP → immediate pc=RESET_PC, valid=0, imem_req=0.
